// File: rtl/m_mul_seq.sv
// Iterative 32x32 RV32M multiplier (MUL/MULH/MULHSU/MULHU): one shift-add step per cycle
// through a shared 64-bit carry-select adder, with sign fix-up on the same adder.

module m_adder (
  input  logic [63:0] i_operand1_64,
  input  logic [63:0] i_operand2_64,
  input  logic        i_cIn_1,
  output logic [63:0] o_sum_64
);
  // Four 16-bit blocks; each precomputes both carry-in cases and the ripple only selects.
  logic [3:0] carry;
  assign carry[0] = i_cIn_1;

  for (genvar g = 0; g < 4; g++) begin : gBlk
    if (g < 3) begin : gMid
      logic [16:0] sum0, sum1;
      assign sum0 = {1'b0, i_operand1_64[g*16 +: 16]} + {1'b0, i_operand2_64[g*16 +: 16]};
      assign sum1 = {1'b0, i_operand1_64[g*16 +: 16]} + {1'b0, i_operand2_64[g*16 +: 16]} + 17'd1;
      assign o_sum_64[g*16 +: 16] = carry[g] ? sum1[15:0] : sum0[15:0];
      assign carry[g+1] = carry[g] ? sum1[16] : sum0[16];
    end else begin : gTop
      logic [15:0] sum0, sum1;
      assign sum0 = i_operand1_64[g*16 +: 16] + i_operand2_64[g*16 +: 16];
      assign sum1 = i_operand1_64[g*16 +: 16] + i_operand2_64[g*16 +: 16] + 16'd1;
      assign o_sum_64[g*16 +: 16] = carry[g] ? sum1 : sum0;
    end
  end
endmodule

module m_mul_seq (
  input  logic        i_clk_1,
  input  logic        i_rst_1,
  input  logic        i_start_1,
  input  logic        i_flush_1,
  input  logic [1:0]  i_op_2,
  input  logic [31:0] i_mulOperand1_32,
  input  logic [31:0] i_mulOperand2_32,
  output logic        o_ready_1,
  output logic        o_valid_1,
  output logic [31:0] o_mulResult_32
);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} mulState_e;

  mulState_e   state, stateNext;
  logic [1:0]  op;
  logic [31:0] a, b, aAbs, bAbs;
  logic [63:0] prod, fixedProd;
  logic [4:0]  cnt;
  logic        neg, negIn, accept;
  logic [63:0] adderOp1, adderOp2, adderSum;
  logic        adderCin;

  m_adder uAdder (
    .i_operand1_64(adderOp1),
    .i_operand2_64(adderOp2),
    .i_cIn_1      (adderCin),
    .o_sum_64     (adderSum)
  );

  assign accept = (state == IDLE) && i_start_1 && !i_flush_1;

  always_comb begin
    negIn = 1'b0;
    case (i_op_2)
      OP_MULH:   negIn = i_mulOperand1_32[31] ^ i_mulOperand2_32[31];
      OP_MULHSU: negIn = i_mulOperand1_32[31];
      default:   negIn = 1'b0;
    endcase
  end

  // 0x80000000 negates to itself and is then treated as unsigned 2^31.
  assign aAbs = ((op == OP_MULH || op == OP_MULHSU) && a[31]) ? (~a + 32'd1) : a;
  assign bAbs = ((op == OP_MULH) && b[31]) ? (~b + 32'd1) : b;
  assign fixedProd = neg ? adderSum : prod;

  always_comb begin
    stateNext = state;
    adderOp1  = 64'd0;
    adderOp2  = 64'd0;
    adderCin  = 1'b0;
    case (state)
      IDLE: if (accept) stateNext = PREP;
      PREP: stateNext = CALC;
      CALC: begin
        adderOp1 = {32'd0, prod[63:32]};
        adderOp2 = prod[0] ? {32'd0, a} : 64'd0;
        if (cnt == 5'd31) stateNext = FIX;
      end
      FIX: begin
        if (neg) begin
          adderOp1 = ~prod;
          adderCin = 1'b1;
        end
        stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (i_flush_1 && state != IDLE) stateNext = IDLE;
  end

  always_ff @(posedge i_clk_1 or posedge i_rst_1) begin
    if (i_rst_1) begin
      state          <= IDLE;
      op             <= 2'b00;
      a              <= 32'd0;
      b              <= 32'd0;
      prod           <= 64'd0;
      cnt            <= 5'd0;
      neg            <= 1'b0;
      o_mulResult_32 <= 32'd0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: if (accept) begin
          op  <= i_op_2;
          a   <= i_mulOperand1_32;
          b   <= i_mulOperand2_32;
          neg <= negIn;
        end
        PREP: begin
          a    <= aAbs;
          b    <= bAbs;
          prod <= {32'd0, bAbs};
          cnt  <= 5'd0;
        end
        CALC: begin
          prod <= {adderSum[32:0], prod[31:1]};
          cnt  <= cnt + 5'd1;
        end
        FIX: begin
          prod <= fixedProd;
          // A flush here aborts the op, so the previous result must survive.
          if (!i_flush_1)
            o_mulResult_32 <= (op == OP_MUL) ? fixedProd[31:0] : fixedProd[63:32];
        end
        default: ;
      endcase
    end
  end

  assign o_ready_1 = (state == IDLE);
  assign o_valid_1 = (state == DONE);
endmodule

// File: tb/tb_m_mul_seq.sv
// Directed bench for m_mul_seq: result values, valid/ready timing, busy start, flush and async reset.

module tb_m_mul_seq;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] opA, opB;
  logic        ready, valid;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  m_mul_seq dut (
    .i_clk_1         (clk),
    .i_rst_1         (rst),
    .i_start_1       (start),
    .i_flush_1       (flush),
    .i_op_2          (op),
    .i_mulOperand1_32(opA),
    .i_mulOperand2_32(opB),
    .o_ready_1       (ready),
    .o_valid_1       (valid),
    .o_mulResult_32  (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_wait"}, {31'd0, ready}, 32'd1);
  endtask

  // Issue one op; optionally pulse start (cycle start_at) or flush (cycle flush_at) while busy.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp,
                        input int start_at, input int flush_at);
    int valid_cyc = 0;
    int n_valid = 0;
    int ready_hi_busy = 0;
    logic [31:0] res_at_valid = 32'd0;
    logic ready_36 = 1'b0, ready_37 = 1'b0, ready_after_flush = 1'b0;
    wait_ready(tag);
    if (flush_at == 0) exp_q.push_back(exp);
    start = 1'b1; op = o; opA = x; opB = y;
    @(posedge clk);
    for (int n = 1; n <= 37; n++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      if (valid) begin
        n_valid++;
        valid_cyc = n;
        res_at_valid = result;
      end
      if (n <= 35 && ready && (flush_at == 0 || n <= flush_at)) ready_hi_busy++;
      if (n == 36) ready_36 = ready;
      if (n == 37) ready_37 = ready;
      if (flush_at != 0 && n == flush_at + 1) ready_after_flush = ready;
      if (n == start_at) begin
        start = 1'b1; op = 2'b00; opA = 32'd3; opB = 32'd5;
      end
      if (n == flush_at) flush = 1'b1;
    end
    if (flush_at == 0) begin
      chk({tag, "_valid_cycle"}, valid_cyc, 32'd35);
      chk({tag, "_valid_count"}, n_valid, 32'd1);
      chk({tag, "_ready_busy"}, ready_hi_busy, 32'd0);
      chk({tag, "_ready_back"}, {30'd0, ready_36, ready_37}, 32'd3);
      chk({tag, "_result"}, res_at_valid, exp_q.pop_front());
      chk({tag, "_result_held"}, result, exp);
      last_exp = exp;
    end else begin
      chk({tag, "_flush_valid"}, n_valid, 32'd0);
      chk({tag, "_flush_ready"}, {31'd0, ready_after_flush}, 32'd1);
      chk({tag, "_flush_busy"}, ready_hi_busy, 32'd0);
      chk({tag, "_flush_result"}, result, last_exp);
    end
  endtask

  initial begin
    int n_valid;
    int n_busy;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; opA = 32'd0; opB = 32'd0;
    last_exp = 32'd0;
    #3;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("mulhu_ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0);
    run_op("mul_ff",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0);
    run_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0);
    run_op("mul_min",  2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 0, 0);
    run_op("mulh_m7",  2'b01, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 0, 0);
    run_op("mul_m7",   2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFEB, 0, 0);
    run_op("mulhsu_m1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_op("mulhsu_2",  2'b10, 32'h00000002, 32'h80000000, 32'h00000001, 0, 0);
    // Busy start at cycle 5 must neither disturb the result nor queue an op.
    run_op("busy_start", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 0);
    // Flush at cycle 10: no pulse, result keeps the previous value.
    run_op("flush10", 2'b01, 32'hFFFFFFF9, 32'h00000003, 32'h0, 0, 10);

    // Flush and start together in IDLE: nothing starts.
    wait_ready("idle_flush");
    start = 1'b1; flush = 1'b1; op = 2'b00; opA = 32'd7; opB = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_valid = 0; n_busy = 0;
    for (int n = 0; n < 40; n++) begin
      if (valid) n_valid++;
      if (!ready) n_busy++;
      @(negedge clk);
    end
    chk("idle_flush_valid", n_valid, 32'd0);
    chk("idle_flush_busy", n_busy, 32'd0);
    chk("idle_flush_result", result, last_exp);

    // Asynchronous reset in the middle of CALC.
    wait_ready("async_rst");
    start = 1'b1; op = 2'b11; opA = 32'hFFFFFFFF; opB = 32'hFFFFFFFF;
    @(posedge clk);
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", {31'd0, ready}, 32'd1);
    chk("async_rst_valid", {31'd0, valid}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_exp = 32'd0;
    @(negedge clk);
    run_op("post_rst_mulhu", 2'b11, 32'd3, 32'd5, 32'h00000000, 0, 0);
    run_op("post_rst_mul",   2'b00, 32'd3, 32'd5, 32'h0000000F, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
